// File: rtl/icmp_pkg.sv
// icmp_pkg: ICMP protocol constants, the parser FSM state encoding shared
// with the TX side, and a helper for placing a byte in its checksum word.
package icmp_pkg;

  localparam logic [7:0]  ICMP_TYPE_ECHO_REQ   = 8'd8;
  localparam logic [7:0]  ICMP_TYPE_ECHO_REPLY = 8'd0;
  localparam logic [7:0]  ICMP_CODE_ECHO       = 8'd0;
  localparam logic [15:0] ICMP_HDR_LEN         = 16'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_DROP,
    ST_FIN
  } icmp_state_t;

  // Even byte indices carry the high half of a 16-bit word, odd ones the low half.
  function automatic logic [15:0] csum_word(input logic [7:0] b, input logic odd);
    return odd ? {8'h00, b} : {b, 8'h00};
  endfunction

endpackage

// File: rtl/icmp_csum_acc.sv
// icmp_csum_acc: one's-complement checksum accumulator for the ICMP parser.
// Bytes are summed into a 32-bit accumulator. The first beat of a message
// restarts the sum. On the last beat the complete sum is folded once into a
// 17-bit stage. On the following cycle the second fold produces o_match,
// which is high when the folded result is 16'hFFFF. Because the complete sum
// moves into the fold stage on the last beat, the accumulator can start on
// the next message in the very next cycle.
module icmp_csum_acc
  import icmp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_beat,
  input  logic       i_first,
  input  logic       i_last,
  input  logic       i_odd,
  input  logic [7:0] i_data,
  output logic       o_match
);

  logic [31:0] acc;
  logic [31:0] sum_next;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Running sum including the current byte, and the second end-around-carry fold.
  always_comb begin
    sum_next = (i_first ? 32'd0 : acc) + {16'd0, csum_word(i_data, i_odd)};
    fold2    = fold1[15:0] + {15'd0, fold1[16]};
  end

  // Accumulate beats, take the first fold on the last beat, then register the match flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc     <= 32'd0;
      fold1   <= 17'd0;
      o_match <= 1'b0;
    end else begin
      if (i_beat) begin
        acc <= sum_next;
      end
      if (i_beat && i_last) begin
        fold1 <= {1'b0, sum_next[15:0]} + {1'b0, sum_next[31:16]};
      end
      o_match <= (fold2 == 16'hFFFF);
    end
  end

endmodule

// File: rtl/icmp_rx.sv
// icmp_rx: receive-side ICMP echo-request parser.
// Validates type/code/length on the fly. A verdict leaves a fixed 2-cycle
// pipeline and produces either o_trig_reply, which updates o_trig_id and
// o_trig_seq, or o_drop. The pipeline runs independently of the byte FSM,
// so the next message may start in the cycle right after a last beat.
// Optional build macro: ICMP_RX_CHECKSUM_EN adds a one's-complement checksum
// check. Without the macro the checksum field is ignored.
module icmp_rx
  import icmp_pkg::*;
#(
  parameter logic [15:0] P_MIN_LEN = 16'd8,
  parameter logic [15:0] P_MAX_LEN = 16'd1480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_icmp_data,
  input  logic [15:0] i_icmp_len,
  input  logic        i_icmp_last,
  input  logic        i_icmp_valid,
  output logic        o_trig_reply,
  output logic [15:0] o_trig_seq,
  output logic [15:0] o_trig_id,
  output logic        o_drop
);

  icmp_state_t state;
  logic [15:0] cnt;
  logic [15:0] len_q;
  logic [15:0] id_sh;
  logic [15:0] seq_sh;

  logic        start;
  logic [15:0] idx;
  logic [15:0] len_eff;
  logic [16:0] count;
  logic        fail_hdr;
  logic        fail_end;
  logic [15:0] seq_cur;

  logic        v1, f1, v2, f2;
  logic [15:0] id1, seq1, id2, seq2;
  logic        csum_ok;

`ifdef ICMP_RX_CHECKSUM_EN
  icmp_csum_acc u_csum (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_beat  (i_icmp_valid),
    .i_first (start),
    .i_last  (i_icmp_last),
    .i_odd   (idx[0]),
    .i_data  (i_icmp_data),
    .o_match (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  // Decode the current beat: its byte index, the effective length, and the header/length checks.
  always_comb begin
    start    = i_icmp_valid && (state == ST_IDLE || state == ST_FIN);
    idx      = start ? 16'd0 : cnt;
    len_eff  = start ? i_icmp_len : len_q;
    count    = {1'b0, idx} + 17'd1;
    fail_hdr = 1'b0;
    if (idx == 16'd0) begin
      fail_hdr = (i_icmp_data != ICMP_TYPE_ECHO_REQ) || (i_icmp_len > P_MAX_LEN);
    end else if (idx == 16'd1) begin
      fail_hdr = (i_icmp_data != ICMP_CODE_ECHO);
    end
    fail_end = (count < {1'b0, P_MIN_LEN}) || (count != {1'b0, len_eff});
    seq_cur  = seq_sh;
    if (state == ST_HDR && idx == 16'd7) begin
      seq_cur = {seq_sh[15:8], i_icmp_data};
    end
  end

  // Byte-level FSM: count beats, latch the length, capture id/seq and track drop state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      cnt    <= 16'd0;
      len_q  <= 16'd0;
      id_sh  <= 16'd0;
      seq_sh <= 16'd0;
    end else if (i_icmp_valid) begin
      cnt <= (idx == 16'hFFFF) ? 16'hFFFF : idx + 16'd1;
      if (start) begin
        len_q <= i_icmp_len;
      end
      if (state == ST_HDR) begin
        case (idx)
          16'd4:   id_sh[15:8]  <= i_icmp_data;
          16'd5:   id_sh[7:0]   <= i_icmp_data;
          16'd6:   seq_sh[15:8] <= i_icmp_data;
          16'd7:   seq_sh[7:0]  <= i_icmp_data;
          default: ;
        endcase
      end
      if (i_icmp_last) begin
        state <= ST_FIN;
      end else if (state == ST_DROP || fail_hdr) begin
        state <= ST_DROP;
      end else if (idx >= ICMP_HDR_LEN - 16'd1) begin
        state <= ST_PAY;
      end else begin
        state <= ST_HDR;
      end
    end else if (state == ST_FIN) begin
      state <= ST_IDLE;
    end
  end

  // Verdict pipeline: two stages after the last beat, then registered reply/drop pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1           <= 1'b0;
      f1           <= 1'b0;
      id1          <= 16'd0;
      seq1         <= 16'd0;
      v2           <= 1'b0;
      f2           <= 1'b0;
      id2          <= 16'd0;
      seq2         <= 16'd0;
      o_trig_reply <= 1'b0;
      o_drop       <= 1'b0;
      o_trig_id    <= 16'd0;
      o_trig_seq   <= 16'd0;
    end else begin
      v1           <= i_icmp_valid && i_icmp_last;
      f1           <= (state == ST_DROP) || fail_hdr || fail_end;
      id1          <= id_sh;
      seq1         <= seq_cur;
      v2           <= v1;
      f2           <= f1;
      id2          <= id1;
      seq2         <= seq1;
      o_trig_reply <= v2 && !f2 && csum_ok;
      o_drop       <= v2 && (f2 || !csum_ok);
      if (v2 && !f2 && csum_ok) begin
        o_trig_id  <= id2;
        o_trig_seq <= seq2;
      end
    end
  end

endmodule

// File: tb/tb_icmp_rx.sv
// tb_icmp_rx: directed bench for icmp_rx. Messages are built in a byte array
// and streamed in. A negedge monitor logs every reply/drop pulse together with
// its cycle number. Each scenario is then checked against hand-derived
// counts, latencies and id/seq values.
module tb_icmp_rx;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_icmp_data;
  logic [15:0] i_icmp_len;
  logic        i_icmp_last;
  logic        i_icmp_valid;
  logic        o_trig_reply;
  logic [15:0] o_trig_seq;
  logic [15:0] o_trig_id;
  logic        o_drop;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]  msg [0:1499];
  int          reply_cyc [$];
  logic [15:0] reply_seq [$];
  logic [15:0] reply_id  [$];
  int          drop_cyc  [$];

  icmp_rx dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_icmp_data  (i_icmp_data),
    .i_icmp_len   (i_icmp_len),
    .i_icmp_last  (i_icmp_last),
    .i_icmp_valid (i_icmp_valid),
    .o_trig_reply (o_trig_reply),
    .o_trig_seq   (o_trig_seq),
    .o_trig_id    (o_trig_id),
    .o_drop       (o_drop)
  );

  always #5 i_clk = ~i_clk;

  // Number each rising edge so pulse latencies can be measured in cycles.
  always @(posedge i_clk) cyc <= cyc + 1;

  // Log every reply and drop pulse away from the active edge.
  always @(negedge i_clk) begin
    if (o_trig_reply) begin
      reply_cyc.push_back(cyc);
      reply_seq.push_back(o_trig_seq);
      reply_id.push_back(o_trig_id);
    end
    if (o_drop) drop_cyc.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    reply_cyc.delete();
    reply_seq.delete();
    reply_id.delete();
    drop_cyc.delete();
  endtask

  task automatic buildMsg(input logic [7:0] typ, input logic [7:0] code, input logic [15:0] csum,
                          input logic [15:0] id, input logic [15:0] seq, input int len);
    logic [7:0] hdr [0:7];
    hdr[0] = typ;        hdr[1] = code;
    hdr[2] = csum[15:8]; hdr[3] = csum[7:0];
    hdr[4] = id[15:8];   hdr[5] = id[7:0];
    hdr[6] = seq[15:8];  hdr[7] = seq[7:0];
    for (int i = 0; i < len; i++) msg[i] = (i < 8) ? hdr[i] : 8'h00;
  endtask

  function automatic logic [15:0] calcCsum(input int len);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < len; i++) begin
      if (i % 2 == 0) s = s + {16'd0, msg[i], 8'd0};
      else            s = s + {24'd0, msg[i]};
    end
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic buildEcho(input logic [15:0] seq, input logic [15:0] id, input int len);
    logic [15:0] c;
    buildMsg(8'd8, 8'd0, 16'h0000, id, seq, len);
    c = calcCsum(len);
    msg[2] = c[15:8];
    msg[3] = c[7:0];
  endtask

  task automatic applyStimulus(input int nbytes, input int len_field, input bit gaps,
                               input bit mark_last, output int last_cyc);
    last_cyc = 0;
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && (i % 5 == 2)) begin
        @(posedge i_clk); #1;
        i_icmp_valid = 1'b0;
        i_icmp_last  = 1'b0;
      end
      @(posedge i_clk); #1;
      i_icmp_valid = 1'b1;
      i_icmp_data  = msg[i];
      i_icmp_len   = len_field[15:0];
      i_icmp_last  = mark_last && (i == nbytes - 1);
      if (i == nbytes - 1) last_cyc = cyc + 1;
    end
  endtask

  task automatic goIdle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      i_icmp_valid = 1'b0;
      i_icmp_last  = 1'b0;
    end
  endtask

  task automatic checkSingle(input string tag, input bit exp_accept, input int last_cyc,
                             input logic [15:0] exp_seq, input logic [15:0] exp_id);
    if (exp_accept) begin
      checkOutput({tag, " reply count"}, reply_cyc.size(), 1);
      checkOutput({tag, " drop count"}, drop_cyc.size(), 0);
      if (reply_cyc.size() > 0) begin
        checkOutput({tag, " reply latency"}, reply_cyc[0] - last_cyc, 2);
        checkOutput({tag, " reply seq"}, reply_seq[0], exp_seq);
        checkOutput({tag, " reply id"}, reply_id[0], exp_id);
      end
    end else begin
      checkOutput({tag, " reply count"}, reply_cyc.size(), 0);
      checkOutput({tag, " drop count"}, drop_cyc.size(), 1);
      if (drop_cyc.size() > 0) begin
        checkOutput({tag, " drop latency"}, drop_cyc[0] - last_cyc, 2);
      end
    end
    checkOutput({tag, " held seq"}, o_trig_seq, exp_seq);
    checkOutput({tag, " held id"}, o_trig_id, exp_id);
    clearLog();
  endtask

  initial begin
    int lc, lc1, lc2, lc3;
    i_rst        = 1'b1;
    i_icmp_valid = 1'b0;
    i_icmp_last  = 1'b0;
    i_icmp_data  = 8'h00;
    i_icmp_len   = 16'd0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset reply", o_trig_reply, 0);
    checkOutput("reset drop", o_drop, 0);
    checkOutput("reset seq", o_trig_seq, 0);
    checkOutput("reset id", o_trig_id, 0);
    i_rst = 1'b0;
    goIdle(2);
    clearLog();

    // 1: valid echo request
    buildMsg(8'd8, 8'd0, 16'hF7F9, 16'h0001, 16'h0005, 40);
    applyStimulus(40, 40, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t1 echo", 1'b1, lc, 16'h0005, 16'h0001);

    // 2: wrong type, then wrong code; previous id/seq must stay
    buildMsg(8'd0, 8'd0, 16'hF7F9, 16'h00AA, 16'h00BB, 40);
    applyStimulus(40, 40, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t2 type0", 1'b0, lc, 16'h0005, 16'h0001);
    buildMsg(8'd8, 8'd1, 16'hF7F8, 16'h00AA, 16'h00BB, 40);
    applyStimulus(40, 40, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t2 code1", 1'b0, lc, 16'h0005, 16'h0001);

    // 3: bad checksum
    buildMsg(8'd8, 8'd0, 16'hF7F8, 16'h0001, 16'h0005, 40);
    applyStimulus(40, 40, 1'b0, 1'b1, lc); goIdle(5);
`ifdef ICMP_RX_CHECKSUM_EN
    checkSingle("t3 badcsum", 1'b0, lc, 16'h0005, 16'h0001);
`else
    checkSingle("t3 badcsum", 1'b1, lc, 16'h0005, 16'h0001);
`endif

    // 4: runt, short against length field, single beat, oversize, max size, header only
    buildEcho(16'h0011, 16'h0022, 6);
    applyStimulus(6, 6, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t4 runt6", 1'b0, lc, 16'h0005, 16'h0001);
    buildEcho(16'h0033, 16'h0044, 40);
    applyStimulus(31, 40, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t4 shortlen", 1'b0, lc, 16'h0005, 16'h0001);
    buildEcho(16'h0033, 16'h0044, 1);
    applyStimulus(1, 1, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t4 single", 1'b0, lc, 16'h0005, 16'h0001);
    buildEcho(16'h0055, 16'h0066, 1481);
    applyStimulus(1481, 1481, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t4 oversize", 1'b0, lc, 16'h0005, 16'h0001);
    buildEcho(16'h0077, 16'h0088, 1480);
    applyStimulus(1480, 1480, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t4 maxlen", 1'b1, lc, 16'h0077, 16'h0088);
    buildEcho(16'h00C3, 16'h00C4, 8);
    applyStimulus(8, 8, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t4 hdronly", 1'b1, lc, 16'h00C3, 16'h00C4);

    // 5: back-to-back requests, the third with valid gaps
    buildEcho(16'h0001, 16'h0010, 40);
    applyStimulus(40, 40, 1'b0, 1'b1, lc1);
    buildEcho(16'h0002, 16'h0010, 40);
    applyStimulus(40, 40, 1'b0, 1'b1, lc2);
    buildEcho(16'h0003, 16'h0010, 40);
    applyStimulus(40, 40, 1'b1, 1'b1, lc3);
    goIdle(6);
    checkOutput("t5 reply count", reply_cyc.size(), 3);
    checkOutput("t5 drop count", drop_cyc.size(), 0);
    if (reply_cyc.size() == 3) begin
      checkOutput("t5 lat1", reply_cyc[0] - lc1, 2);
      checkOutput("t5 lat2", reply_cyc[1] - lc2, 2);
      checkOutput("t5 lat3", reply_cyc[2] - lc3, 2);
      checkOutput("t5 seq1", reply_seq[0], 16'h0001);
      checkOutput("t5 seq2", reply_seq[1], 16'h0002);
      checkOutput("t5 seq3", reply_seq[2], 16'h0003);
    end
    clearLog();

    // 6: reset in the middle of a request, then a clean request
    buildEcho(16'h0007, 16'h0020, 40);
    applyStimulus(20, 40, 1'b0, 1'b0, lc);
    @(posedge i_clk); #1;
    i_icmp_data = msg[20];
    i_rst       = 1'b1;
    @(posedge i_clk); #1;
    i_rst        = 1'b0;
    i_icmp_valid = 1'b0;
    goIdle(4);
    checkOutput("t6 seq after reset", o_trig_seq, 16'h0000);
    buildEcho(16'h0009, 16'h0021, 40);
    applyStimulus(40, 40, 1'b0, 1'b1, lc); goIdle(5);
    checkSingle("t6 after reset", 1'b1, lc, 16'h0009, 16'h0021);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
